// File: rtl/ptw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ptw_pkg
//  Description : Shared types and constants for the N-level page-table walker:
//                walker state encoding, fault codes and PTE bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package ptw_pkg;

    // Walker states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MREQ  = 2'd1,
        MWAIT = 2'd2,
        RESP  = 2'd3
    } ptw_state_t;

    // Fault codes reported with the response
    localparam logic [1:0] c_fault_none   = 2'b00;
    localparam logic [1:0] c_fault_page   = 2'b01;
    localparam logic [1:0] c_fault_access = 2'b10;

    // PTE bit positions
    localparam int c_pte_v      = 0;
    localparam int c_pte_r      = 1;
    localparam int c_pte_w      = 2;
    localparam int c_pte_x      = 3;
    localparam int c_pte_ppn_lo = 10;
    localparam int c_pte_ppn_hi = 31;

endpackage : ptw_pkg
`default_nettype wire

// File: rtl/ptw_pte_check.sv
`default_nettype none
// ============================================================================
//  Module      : ptw_pte_check
//  Description : Combinational classification of one PTE at a given level:
//                page fault, valid leaf, or pointer to the next level.
//  Revision    : 1.0 - initial release
// ============================================================================
module ptw_pte_check
    import ptw_pkg::*;
#(
    parameter int VPN_W = 10
) (
    input  logic [31:0] i_pte,
    input  logic [1:0]  i_lvl,
    output logic        o_page_fault,
    output logic        o_leaf,
    output logic        o_descend
);

    logic        w_v;
    logic        w_r;
    logic        w_w;
    logic        w_x;
    logic        w_is_leaf;
    logic [21:0] w_ppn;
    logic [31:0] w_nbits;
    logic [21:0] w_mask;
    logic        w_misaligned;
    logic        w_unused_bits;

    assign w_v       = i_pte[c_pte_v];
    assign w_r       = i_pte[c_pte_r];
    assign w_w       = i_pte[c_pte_w];
    assign w_x       = i_pte[c_pte_x];
    assign w_is_leaf = w_r | w_x;
    assign w_ppn     = i_pte[c_pte_ppn_hi:c_pte_ppn_lo];

    // Software/accessed/dirty bits play no part in the walk decision
    assign w_unused_bits = ^i_pte[9:4];

    // A superpage leaf must have its low lvl*VPN_W PPN bits clear
    assign w_nbits      = 32'(i_lvl) * 32'(VPN_W);
    assign w_mask       = (w_nbits >= 32'd22) ? {22{1'b1}} : ~({22{1'b1}} << w_nbits);
    assign w_misaligned = w_is_leaf && (i_lvl != 2'd0) && (|(w_ppn & w_mask));

    assign o_page_fault = ~w_v
                        | (w_w & ~w_r)
                        | w_misaligned
                        | (~w_is_leaf & (i_lvl == 2'd0));
    assign o_leaf       = ~o_page_fault & w_is_leaf;
    assign o_descend    = ~o_page_fault & ~w_is_leaf;

endmodule : ptw_pte_check
`default_nettype wire

// File: rtl/ptw_nlevel.sv
`default_nettype none
// ============================================================================
//  Module      : ptw_nlevel
//  Description : Single-outstanding N-level page-table walker. Reads one PTE
//                per level over a valid/ready memory port and returns the leaf
//                PTE or a fault code. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module ptw_nlevel
    import ptw_pkg::*;
#(
    parameter  int LEVELS = 2,
    parameter  int VPN_W  = 10,
    parameter  int PA_W   = 32,
    localparam int VA_W   = 12 + LEVELS * VPN_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [21:0]     satp_ppn_i,
    input  logic            ptw_req_valid_i,
    output logic            ptw_req_ready_o,
    input  logic [VA_W-1:0] ptw_vaddr_i,
    output logic            ptw_resp_valid_o,
    input  logic            ptw_resp_ready_i,
    output logic [31:0]     ptw_pte_o,
    output logic [1:0]      ptw_level_o,
    output logic [1:0]      ptw_fault_o,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [PA_W-1:0] mem_addr_o,
    input  logic            mem_resp_valid_i,
    output logic            mem_resp_ready_o,
    input  logic [31:0]     mem_data_i,
    input  logic            mem_resp_err_i
);

    ptw_state_t      r_state,   w_state_nxt;
    logic [VA_W-1:0] r_vaddr,   w_vaddr_nxt;
    logic [1:0]      r_lvl,     w_lvl_nxt;

    logic            w_req_ready_nxt;
    logic            w_resp_valid_nxt;
    logic [31:0]     w_pte_nxt;
    logic [1:0]      w_level_nxt;
    logic [1:0]      w_fault_nxt;
    logic            w_mreq_valid_nxt;
    logic [PA_W-1:0] w_maddr_nxt;
    logic            w_mresp_ready_nxt;

    logic            w_page_fault;
    logic            w_leaf;
    logic            w_descend;
    logic [PA_W-1:0] w_root_base;
    logic [PA_W-1:0] w_next_base;

    // PTE address for one level: base + vpn[lvl]*4, truncated to PA_W
    function automatic logic [PA_W-1:0] f_pte_addr(
        input logic [PA_W-1:0] base,
        input logic [VA_W-1:0] va,
        input logic [1:0]      lvl
    );
        logic [VA_W-1:0]  sh;
        logic [VPN_W-1:0] vpn;
        sh  = va >> (12 + int'(lvl) * VPN_W);
        vpn = sh[VPN_W-1:0];
        return base + PA_W'({vpn, 2'b00});
    endfunction

    assign w_root_base = PA_W'({satp_ppn_i, 12'h000});
    assign w_next_base = PA_W'({mem_data_i[c_pte_ppn_hi:c_pte_ppn_lo], 12'h000});

    ptw_pte_check #(
        .VPN_W        (VPN_W)
    ) u_pte_check (
        .i_pte        (mem_data_i),
        .i_lvl        (r_lvl),
        .o_page_fault (w_page_fault),
        .o_leaf       (w_leaf),
        .o_descend    (w_descend)
    );

    // Next-state and next-output computation; every output is re-registered
    always_comb begin
        w_state_nxt       = r_state;
        w_vaddr_nxt       = r_vaddr;
        w_lvl_nxt         = r_lvl;
        w_req_ready_nxt   = ptw_req_ready_o;
        w_resp_valid_nxt  = ptw_resp_valid_o;
        w_pte_nxt         = ptw_pte_o;
        w_level_nxt       = ptw_level_o;
        w_fault_nxt       = ptw_fault_o;
        w_mreq_valid_nxt  = mem_req_valid_o;
        w_maddr_nxt       = mem_addr_o;
        w_mresp_ready_nxt = mem_resp_ready_o;

        case (r_state)
            IDLE: begin
                if (ptw_req_valid_i && ptw_req_ready_o) begin
                    w_vaddr_nxt      = ptw_vaddr_i;
                    w_lvl_nxt        = 2'(LEVELS - 1);
                    w_req_ready_nxt  = 1'b0;
                    w_mreq_valid_nxt = 1'b1;
                    w_maddr_nxt      = f_pte_addr(w_root_base, ptw_vaddr_i, 2'(LEVELS - 1));
                    w_state_nxt      = MREQ;
                end
            end
            MREQ: begin
                if (mem_req_ready_i) begin
                    w_mreq_valid_nxt  = 1'b0;
                    w_mresp_ready_nxt = 1'b1;
                    w_state_nxt       = MWAIT;
                end
            end
            MWAIT: begin
                if (mem_resp_valid_i && mem_resp_ready_o) begin
                    w_mresp_ready_nxt = 1'b0;
                    if (!mem_resp_err_i && w_descend) begin
                        w_lvl_nxt        = r_lvl - 2'd1;
                        w_mreq_valid_nxt = 1'b1;
                        w_maddr_nxt      = f_pte_addr(w_next_base, r_vaddr, r_lvl - 2'd1);
                        w_state_nxt      = MREQ;
                    end else begin
                        w_resp_valid_nxt = 1'b1;
                        w_level_nxt      = r_lvl;
                        w_state_nxt      = RESP;
                        if (mem_resp_err_i) begin
                            w_pte_nxt   = 32'h0;
                            w_fault_nxt = c_fault_access;
                        end else if (w_page_fault) begin
                            w_pte_nxt   = 32'h0;
                            w_fault_nxt = c_fault_page;
                        end else begin
                            w_pte_nxt   = mem_data_i;
                            w_fault_nxt = c_fault_none;
                        end
                    end
                end
            end
            RESP: begin
                if (ptw_resp_ready_i) begin
                    w_resp_valid_nxt = 1'b0;
                    w_req_ready_nxt  = 1'b1;
                    w_state_nxt      = IDLE;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_req_ready_nxt = 1'b1;
            end
        endcase

        // w_leaf is implied by !fault && !descend; kept for readability
        if (w_leaf && w_descend) begin
            w_state_nxt = r_state;
        end
    end

    // State, walk context and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_vaddr          <= '0;
            r_lvl            <= '0;
            ptw_req_ready_o  <= 1'b1;
            ptw_resp_valid_o <= 1'b0;
            ptw_pte_o        <= '0;
            ptw_level_o      <= '0;
            ptw_fault_o      <= '0;
            mem_req_valid_o  <= 1'b0;
            mem_addr_o       <= '0;
            mem_resp_ready_o <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_vaddr          <= w_vaddr_nxt;
            r_lvl            <= w_lvl_nxt;
            ptw_req_ready_o  <= w_req_ready_nxt;
            ptw_resp_valid_o <= w_resp_valid_nxt;
            ptw_pte_o        <= w_pte_nxt;
            ptw_level_o      <= w_level_nxt;
            ptw_fault_o      <= w_fault_nxt;
            mem_req_valid_o  <= w_mreq_valid_nxt;
            mem_addr_o       <= w_maddr_nxt;
            mem_resp_ready_o <= w_mresp_ready_nxt;
        end
    end

endmodule : ptw_nlevel
`default_nettype wire
